tc_a_sched: RTL
===============

# tc_a_sched

Sequencer for the tensor-core A-operand path. It takes a GEMM tile command, streams A fragments from the A operand buffer, and presents them to the A distribution network. That network registers its input once, then broadcasts each 4-element row to all 4 PEs. The block sits between the command front-end, the A buffer and the distribution network. It produces per-beat valid and accumulator-control tags aligned with the network output.

## Interface
Parameters:
- NUM_TILE, 16, elements per A fragment (one beat)
- DW_DATA, 16, bits per element
- N_PE, 4, PEs fed by the distribution network (informational; no width here depends on it)
- ADDR_W, 8, A-buffer address width
- CNT_W, 8, width of the K-step and M-tile counts

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_base  in  ADDR_W  A-buffer address of the first fragment
- cmd_ksteps  in  CNT_W  fragments per M-tile (K direction)
- cmd_mtiles  in  CNT_W  number of M-tiles
- pe_ready  in  1  PE array can accept new issues
- buf_rd_en  out  1  A-buffer read strobe; read latency is exactly 1 cycle
- buf_rd_addr  out  ADDR_W  A-buffer read address
- buf_rd_data  in  NUM_TILE*DW_DATA  A-buffer read data
- dn_in_a  out  NUM_TILE*DW_DATA  distribution-network input
- dn_valid  out  1  the network output is valid this cycle
- acc_clear  out  1  with dn_valid: first K-step of an M-tile
- acc_last  out  1  with dn_valid: last K-step of an M-tile
- busy  out  1  high from command accept until done
- done  out  1  one-cycle pulse when the command completes
- perf_stall_cycles  out  32  present only with TC_A_SCHED_PERF_EN

## Operation
- FSM states and transitions:
  - IDLE: cmd_ready=1. A handshake latches base, ksteps and mtiles, clears k and m, and moves to RUN. If ksteps==0 or mtiles==0 it moves to DRAIN instead.
  - RUN: each cycle with pe_ready=1, issue one read: buf_rd_en=1, buf_rd_addr=addr. Then increment addr, modulo 2^ADDR_W.
    - k counts 0..ksteps-1. At wrap, k returns to 0 and m increments.
    - When the issue with k==ksteps-1 and m==mtiles-1 happens, move to DRAIN.
    - If pe_ready=0, no issue and the counters hold.
  - DRAIN: wait until the 2-deep in-flight tag pipe is empty, then move to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Addresses are contiguous, row-major: address = base + m*ksteps + k, generated incrementally with no multiplier. Addresses wrap silently past 2^ADDR_W-1.
- Each issue pushes a tag {valid, first = k==0, last = k==ksteps-1} into a 2-stage shift pipe. Stage 1 output drives dn_valid, acc_clear and acc_last.
- dn_in_a = buf_rd_data, passed through combinationally. The distribution network provides the register stage.
- Backpressure contract: pe_ready gates only new issues. The PE array accepts up to 2 in-flight beats after it deasserts pe_ready.
- A command is never accepted while busy.
- reset in any state, including mid-RUN or DRAIN:
  - FSM goes to IDLE; counters, tag pipe and address clear.
  - In-flight beats are discarded: no dn_valid appears after reset.
- Reset values: cmd_ready=1 from the first cycle after reset; buf_rd_en=0, buf_rd_addr=0, dn_valid=0, acc_clear=0, acc_last=0, busy=0, done=0, perf_stall_cycles=0.
- dn_in_a is unregistered and follows buf_rd_data, so it has no reset value of its own.

## Timing
- Cycle 0: cmd handshake.
- Cycle 1: first issue, if pe_ready=1.
- Cycle 2: data on buf_rd_data and dn_in_a.
- Cycle 3: the network outputs the data; dn_valid, acc_clear and acc_last are high.
- Issue-to-dn_valid latency: 2 cycles. Throughput: 1 beat per cycle while pe_ready=1.
- done is asserted the cycle after the last dn_valid (DRAIN lasts 2 cycles after the last issue). busy falls with done.
- Zero-size command: handshake at cycle 0, DRAIN at cycle 1, done at cycle 2, no reads.
- ksteps==1: acc_clear and acc_last are both high on every beat.

## Configuration
- TC_A_SCHED_PERF_EN defined: perf_stall_cycles is present.
  - It is a 32-bit saturating counter of cycles in RUN with pe_ready=0.
  - It clears on reset and on each command accept.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

## Structure
- Package tc_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE}
  - the tag struct {valid, first, last}
  - the default DW_DATA and NUM_TILE constants
- The one natural sub-module is tc_tag_pipe: a parameterised-depth tag shift register with synchronous clear, instantiated here with depth 2.

## Test plan
- base=0x10, ksteps=3, mtiles=2, pe_ready=1:
  - reads 0x10..0x15 on consecutive cycles
  - acc_clear on beats 0 and 3; acc_last on beats 2 and 5
  - done 3 cycles after the last issue
- base=0xFE, ksteps=4, mtiles=1 -> addresses FE, FF, 00, 01.
- ksteps=4, mtiles=1, pe_ready low during cycles 2-3:
  - issues pause for exactly 2 cycles; dn_valid shows the matching 2-cycle gap
  - perf_stall_cycles=2 (PERF_EN build)
- ksteps=0, mtiles=5 -> no buf_rd_en; done at cycle 2.
- reset asserted the cycle after the second issue:
  - all outputs return to their reset values
  - no later dn_valid
  - a new command is accepted the next cycle
- cmd_valid held high through completion -> only one accept while busy; the second accept is in IDLE after done.

Source files
------------

// File: rtl/tc_pkg.sv
// Shared types and defaults for the tensor-core A-operand sequencer.
package tc_pkg;

  localparam int unsigned NumTileDef   = 16;
  localparam int unsigned DwDataDef    = 16;
  localparam int unsigned TagPipeDepth = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/tc_tag_pipe.sv
// Fixed-latency shift register carrying per-beat tags alongside the A data.
module tc_tag_pipe
  import tc_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  tag_t push_tag,
  output tag_t head_tag,
  output logic pending
);

  tag_t stage_q [Depth];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= push_tag;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign head_tag = stage_q[Depth-1];

  // The head stage leaves on the next edge, so only earlier stages keep the pipe occupied.
  always_comb begin
    pending = 1'b0;
    for (int unsigned i = 0; i + 1 < Depth; i++) begin
      pending = pending | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/tc_a_sched.sv
// A-operand sequencer: walks a GEMM tile command over the A buffer and tags each beat.
// Optional stall counter port enabled by defining TC_A_SCHED_PERF_EN.
module tc_a_sched
  import tc_pkg::*;
#(
  parameter int unsigned NUM_TILE = NumTileDef,
  parameter int unsigned DW_DATA  = DwDataDef,
  parameter int unsigned N_PE     = 4,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [ADDR_W-1:0]           cmd_base,
  input  logic [CNT_W-1:0]            cmd_ksteps,
  input  logic [CNT_W-1:0]            cmd_mtiles,
  input  logic                        pe_ready,
  output logic                        buf_rd_en,
  output logic [ADDR_W-1:0]           buf_rd_addr,
  input  logic [NUM_TILE*DW_DATA-1:0] buf_rd_data,
  output logic [NUM_TILE*DW_DATA-1:0] dn_in_a,
  output logic                        dn_valid,
  output logic                        acc_clear,
  output logic                        acc_last,
  output logic                        busy,
`ifdef TC_A_SCHED_PERF_EN
  output logic [31:0]                 perf_stall_cycles,
`endif
  output logic                        done
);

  if (N_PE == 0) begin : g_bad_n_pe
    $error("N_PE must be nonzero");
  end

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]    m_q, m_d;
  logic [CNT_W-1:0]    ksteps_q, ksteps_d;
  logic [CNT_W-1:0]    mtiles_q, mtiles_d;

  logic accept;
  logic issue;
  logic k_last;
  logic m_last;
  logic pipe_pending;
  tag_t push_tag;
  tag_t head_tag;

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign issue     = (state_q == StRun) & pe_ready;
  assign k_last    = (k_q == ksteps_q - CNT_W'(1));
  assign m_last    = (m_q == mtiles_q - CNT_W'(1));

  assign buf_rd_en   = issue;
  assign buf_rd_addr = addr_q;
  assign dn_in_a     = buf_rd_data;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    k_d      = k_q;
    m_d      = m_q;
    ksteps_d = ksteps_q;
    mtiles_d = mtiles_q;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ksteps_d = cmd_ksteps;
          mtiles_d = cmd_mtiles;
          addr_d   = cmd_base;
          k_d      = '0;
          m_d      = '0;
          if (cmd_ksteps == '0 || cmd_mtiles == '0) begin
            state_d = StDrain;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        // Row-major walk: the address simply advances by one per issue.
        if (pe_ready) begin
          addr_d = addr_q + ADDR_W'(1);
          if (k_last) begin
            k_d = '0;
            m_d = m_q + CNT_W'(1);
            if (m_last) begin
              state_d = StDrain;
            end
          end else begin
            k_d = k_q + CNT_W'(1);
          end
        end
      end
      StDrain: begin
        if (!pipe_pending) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      k_q      <= '0;
      m_q      <= '0;
      ksteps_q <= '0;
      mtiles_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      m_q      <= m_d;
      ksteps_q <= ksteps_d;
      mtiles_q <= mtiles_d;
    end
  end

  always_comb begin
    push_tag       = '0;
    push_tag.valid = issue;
    push_tag.first = issue & (k_q == '0);
    push_tag.last  = issue & k_last;
  end

  tc_tag_pipe #(
    .Depth(TagPipeDepth)
  ) u_tag_pipe (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .push_tag (push_tag),
    .head_tag (head_tag),
    .pending  (pipe_pending)
  );

  assign dn_valid  = head_tag.valid;
  assign acc_clear = head_tag.first;
  assign acc_last  = head_tag.last;

`ifdef TC_A_SCHED_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      stall_q <= '0;
    end else if (state_q == StRun && !pe_ready && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
`endif

endmodule
